// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII byte adapter: FSM state encodings,
// in-band speed encoding and the default inter-frame gap.
package rgmii_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_IFG
  } tx_state_t;

  localparam logic [1:0] SPEED_10M   = 2'b00;
  localparam logic [1:0] SPEED_100M  = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;

  localparam int         IFG_BYTES_DEFAULT = 12;
  localparam logic [7:0] SFD_BYTE          = 8'hD5;

endpackage

// File: rtl/rgmii_byte_adapter_if.sv
// Received byte stream with frame markers; master is the producer (RX assembler),
// slave is the consumer.
interface rgmii_byte_adapter_if;
  logic [7:0] data;
  logic       valid;
  logic       sof;
  logic       err;
  logic       eof;
  logic       eof_err;

  modport master (output data, valid, sof, err, eof, eof_err);
  modport slave  (input  data, valid, sof, err, eof, eof_err);
endinterface

// File: rtl/rgmii_rx_assembler.sv
// RGMII receive path: turns DDR captures into bytes (byte or nibble mode) with
// sof/eof markers; STRIP_PRE suppresses preamble/SFD ahead of the first byte.
module rgmii_rx_assembler
  import rgmii_pkg::*;
#(
  parameter int STRIP_PRE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 speed_sel,
  input  logic [7:0]           ddr_rxd,
  input  logic [1:0]           ddr_rxctl,
  rgmii_byte_adapter_if.master rx
);
  localparam bit STRIP = (STRIP_PRE != 0);

  rx_state_t  state, state_next;
  logic       rx_dv, rx_er;
  logic       armed, speed_q, phase, lo_err, sfd_seen, delivered, err_any;
  logic [3:0] lo_nib;
  logic       frame_start, frame_end, active;
  logic       mode_byte, cur_phase, sfd_prev, deliv_prev, err_prev;
  logic       byte_rdy, byte_err, deliver, hit_sfd;
  logic [7:0] byte_val;

  assign rx_dv = ddr_rxctl[0];
  assign rx_er = ddr_rxctl[0] ^ ddr_rxctl[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  // A reset in the middle of a frame leaves armed low, so the tail of that frame is ignored.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE: if (rx_dv && armed) state_next = RX_RECV;
      RX_RECV: if (!rx_dv)         state_next = RX_IDLE;
      default:                     state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    frame_start = (state == RX_IDLE) && rx_dv && armed;
    frame_end   = (state == RX_RECV) && !rx_dv;
    active      = frame_start || ((state == RX_RECV) && rx_dv);
  end

  // On the first cycle of a frame the per-frame history reads as cleared.
  always_comb begin
    mode_byte  = frame_start ? speed_sel : speed_q;
    cur_phase  = frame_start ? 1'b0 : phase;
    sfd_prev   = frame_start ? 1'b0 : sfd_seen;
    deliv_prev = frame_start ? 1'b0 : delivered;
    err_prev   = frame_start ? 1'b0 : err_any;
    byte_val   = mode_byte ? ddr_rxd : {ddr_rxd[3:0], lo_nib};
    byte_err   = rx_er | (~mode_byte & lo_err);
    byte_rdy   = active & (mode_byte | cur_phase);
    hit_sfd    = byte_rdy & STRIP & ~sfd_prev & (byte_val == SFD_BYTE);
    deliver    = byte_rdy & (~STRIP | sfd_prev);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      speed_q   <= 1'b0;
      phase     <= 1'b0;
      lo_nib    <= 4'h0;
      lo_err    <= 1'b0;
      sfd_seen  <= 1'b0;
      delivered <= 1'b0;
      err_any   <= 1'b0;
    end else begin
      if (!rx_dv)      armed   <= 1'b1;
      if (frame_start) speed_q <= speed_sel;
      if (active) begin
        phase     <= mode_byte ? 1'b0 : ~cur_phase;
        sfd_seen  <= sfd_prev | hit_sfd;
        delivered <= deliv_prev | deliver;
        err_any   <= err_prev | (deliver & byte_err);
        if (!mode_byte && !cur_phase) begin
          lo_nib <= ddr_rxd[3:0];
          lo_err <= rx_er;
        end
      end
    end
  end

  // A dangling low nibble (phase still 1 at frame end) marks the frame bad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.data    <= 8'h00;
      rx.valid   <= 1'b0;
      rx.sof     <= 1'b0;
      rx.err     <= 1'b0;
      rx.eof     <= 1'b0;
      rx.eof_err <= 1'b0;
    end else begin
      rx.valid   <= deliver;
      rx.sof     <= deliver & ~deliv_prev;
      rx.err     <= deliver & byte_err;
      if (deliver) rx.data <= byte_val;
      rx.eof     <= frame_end & delivered;
      rx.eof_err <= frame_end & delivered &
                    (err_any | (~speed_q & phase) | (STRIP & ~sfd_seen));
    end
  end

endmodule

// File: rtl/rgmii_byte_adapter.sv
// RGMII MAC-side byte adapter: RX assembler instance plus TX serializer with IFG.
// Define RGMII_INBAND_STATUS_EN to decode in-band link status from idle RX cycles.
module rgmii_byte_adapter
  import rgmii_pkg::*;
#(
  parameter int IFG_BYTES    = IFG_BYTES_DEFAULT,
  parameter int RX_STRIP_PRE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_speed1000,
  input  logic [7:0] i_ddr_rxd,
  input  logic [1:0] i_ddr_rxctl,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_sof,
  output logic       o_rx_err,
  output logic       o_rx_eof,
  output logic       o_rx_eof_err,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_ddr_txd,
  output logic [1:0] o_ddr_txctl,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_link_fdx
);
  localparam logic [8:0] IFG_LOAD_BYTE = 9'(IFG_BYTES - 1);
  localparam logic [8:0] IFG_LOAD_NIB  = 9'(2 * IFG_BYTES - 1);

  rgmii_byte_adapter_if rx_bus ();

  rgmii_rx_assembler #(
    .STRIP_PRE (RX_STRIP_PRE)
  ) u_rx (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .speed_sel (i_speed1000),
    .ddr_rxd   (i_ddr_rxd),
    .ddr_rxctl (i_ddr_rxctl),
    .rx        (rx_bus.master)
  );

  assign o_rx_data    = rx_bus.data;
  assign o_rx_valid   = rx_bus.valid;
  assign o_rx_sof     = rx_bus.sof;
  assign o_rx_err     = rx_bus.err;
  assign o_rx_eof     = rx_bus.eof;
  assign o_rx_eof_err = rx_bus.eof_err;

  tx_state_t  tx_state, tx_state_next;
  logic       tx_speed, tx_phase, tx_mode;
  logic [3:0] hi_nib;
  logic [8:0] ifg_cnt;
  logic       accept_slot, take, end_frame, hi_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE: if (i_tx_valid)                tx_state_next = TX_SEND;
      TX_SEND: if (accept_slot && !i_tx_valid) tx_state_next = TX_IFG;
      TX_IFG:  if (ifg_cnt == 9'd0)            tx_state_next = TX_IDLE;
      default:                                 tx_state_next = TX_IDLE;
    endcase
  end

  // In nibble mode only phase 0 may take a byte; phase 1 replays the held high nibble.
  always_comb begin
    accept_slot = 1'b0;
    case (tx_state)
      TX_IDLE: accept_slot = 1'b1;
      TX_SEND: accept_slot = tx_speed | ~tx_phase;
      default: accept_slot = 1'b0;
    endcase
    tx_mode   = (tx_state == TX_IDLE) ? i_speed1000 : tx_speed;
    take      = accept_slot & i_tx_valid;
    end_frame = (tx_state == TX_SEND) & accept_slot & ~i_tx_valid;
    hi_slot   = (tx_state == TX_SEND) & ~accept_slot;
  end

  assign o_tx_ready = i_rst_n & accept_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_speed    <= 1'b0;
      tx_phase    <= 1'b0;
      hi_nib      <= 4'h0;
      ifg_cnt     <= 9'd0;
      o_ddr_txd   <= 8'h00;
      o_ddr_txctl <= 2'b00;
    end else begin
      if (tx_state == TX_IDLE && i_tx_valid) tx_speed <= i_speed1000;
      if (take) begin
        o_ddr_txctl <= 2'b11;
        if (tx_mode) begin
          o_ddr_txd <= i_tx_data;
          tx_phase  <= 1'b0;
        end else begin
          o_ddr_txd <= {2{i_tx_data[3:0]}};
          hi_nib    <= i_tx_data[7:4];
          tx_phase  <= 1'b1;
        end
      end else if (hi_slot) begin
        o_ddr_txd   <= {2{hi_nib}};
        o_ddr_txctl <= 2'b11;
        tx_phase    <= 1'b0;
      end else begin
        o_ddr_txd   <= 8'h00;
        o_ddr_txctl <= 2'b00;
      end
      if (end_frame)
        ifg_cnt <= tx_speed ? IFG_LOAD_BYTE : IFG_LOAD_NIB;
      else if (tx_state == TX_IFG && ifg_cnt != 9'd0)
        ifg_cnt <= ifg_cnt - 9'd1;
    end
  end

`ifdef RGMII_INBAND_STATUS_EN
  logic rx_dv, rx_er;
  assign rx_dv = i_ddr_rxctl[0];
  assign rx_er = i_ddr_rxctl[0] ^ i_ddr_rxctl[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_link_up    <= 1'b0;
      o_link_speed <= 2'b00;
      o_link_fdx   <= 1'b0;
    end else if (!rx_dv && !rx_er) begin
      o_link_up    <= i_ddr_rxd[0];
      o_link_speed <= i_ddr_rxd[2:1];
      o_link_fdx   <= i_ddr_rxd[3];
    end
  end
`else
  assign o_link_up    = 1'b0;
  assign o_link_speed = 2'b00;
  assign o_link_fdx   = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_byte_adapter.sv
// Directed bench for rgmii_byte_adapter: one DUT without and one with preamble strip,
// sharing all inputs; RX and TX sequences with hand-computed expectations.
module tb_rgmii_byte_adapter;
  import rgmii_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       speed1000;
  logic [7:0] ddr_rxd;
  logic [1:0] ddr_rxctl;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] ddr_txd;
  logic [1:0] ddr_txctl;
  logic       link_up, link_fdx;
  logic [1:0] link_speed;

  logic [7:0] s_data, s_txd;
  logic       s_valid, s_sof, s_err, s_eof, s_eof_err, s_tx_ready, s_link_up, s_link_fdx;
  logic [1:0] s_txctl, s_link_speed;

  int n_checks = 0;
  int n_fail   = 0;
  int gap_cycles, gap_bad;

  logic [7:0] q_data[$];
  logic       q_sof[$];
  logic       q_err[$];
  logic [7:0] s_q_data[$];
  logic       s_q_sof[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_tx[$];

  rgmii_byte_adapter_if rx_bus ();

  rgmii_byte_adapter #(.IFG_BYTES(12), .RX_STRIP_PRE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_speed1000(speed1000),
    .i_ddr_rxd(ddr_rxd), .i_ddr_rxctl(ddr_rxctl),
    .o_rx_data(rx_bus.data), .o_rx_valid(rx_bus.valid), .o_rx_sof(rx_bus.sof),
    .o_rx_err(rx_bus.err), .o_rx_eof(rx_bus.eof), .o_rx_eof_err(rx_bus.eof_err),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_ddr_txd(ddr_txd), .o_ddr_txctl(ddr_txctl),
    .o_link_up(link_up), .o_link_speed(link_speed), .o_link_fdx(link_fdx)
  );

  rgmii_byte_adapter #(.IFG_BYTES(12), .RX_STRIP_PRE(1)) dut_strip (
    .i_clk(clk), .i_rst_n(rst_n), .i_speed1000(speed1000),
    .i_ddr_rxd(ddr_rxd), .i_ddr_rxctl(ddr_rxctl),
    .o_rx_data(s_data), .o_rx_valid(s_valid), .o_rx_sof(s_sof),
    .o_rx_err(s_err), .o_rx_eof(s_eof), .o_rx_eof_err(s_eof_err),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(s_tx_ready),
    .o_ddr_txd(s_txd), .o_ddr_txctl(s_txctl),
    .o_link_up(s_link_up), .o_link_speed(s_link_speed), .o_link_fdx(s_link_fdx)
  );

  always #5 clk = ~clk;

  // Outputs are collected on the falling edge, half a cycle clear of the active edge.
  always @(negedge clk) begin
    if (rx_bus.valid) begin
      q_data.push_back(rx_bus.data);
      q_sof.push_back(rx_bus.sof);
      q_err.push_back(rx_bus.err);
    end
    if (s_valid) begin
      s_q_data.push_back(s_data);
      s_q_sof.push_back(s_sof);
    end
    if (ddr_txctl == 2'b11) tx_q.push_back(ddr_txd);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [1:0] ctl_of(input logic dv, input logic er);
    return {dv ^ er, dv};
  endfunction

  task automatic applyStimulus(input logic [1:0] ctl, input logic [7:0] rxd);
    ddr_rxctl = ctl;
    ddr_rxd   = rxd;
    tick();
  endtask

  task automatic applyNibble(input logic [3:0] n, input logic er);
    applyStimulus(ctl_of(1'b1, er), {n, n});
  endtask

  task automatic clearQueues();
    q_data.delete(); q_sof.delete(); q_err.delete();
    s_q_data.delete(); s_q_sof.delete(); tx_q.delete();
  endtask

  task automatic sendTx(input logic [7:0] b);
    int guard = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && guard < 200) begin
      gap_cycles++;
      if (ddr_txctl != 2'b00) gap_bad++;
      tick();
      guard++;
    end
    if (!tx_ready) checkOutput("tx_ready_timeout", tx_ready, 1'b1);
    tick();
  endtask

  task automatic endTx();
    int guard = 0;
    tx_valid = 1'b0;
    while (!tx_ready && guard < 10) begin
      tick();
      guard++;
    end
    if (!tx_ready) checkOutput("tx_end_timeout", tx_ready, 1'b1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; speed1000 = 1'b1; ddr_rxd = 8'h0D; ddr_rxctl = 2'b00;
    tx_valid = 1'b0; tx_data = 8'h00;
    #1;
    checkOutput("rst_tx_ready", tx_ready, 1'b0);
    checkOutput("rst_txctl", ddr_txctl, 2'b00);
    checkOutput("rst_txd", ddr_txd, 8'h00);
    checkOutput("rst_rx_valid", rx_bus.valid, 1'b0);
    checkOutput("rst_rx_eof", rx_bus.eof, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_tx_ready", tx_ready, 1'b1);
`ifdef RGMII_INBAND_STATUS_EN
    checkOutput("link_up", link_up, 1'b1);
    checkOutput("link_speed", link_speed, SPEED_1000M);
    checkOutput("link_fdx", link_fdx, 1'b1);
`else
    checkOutput("link_up", link_up, 1'b0);
    checkOutput("link_speed", link_speed, SPEED_10M);
    checkOutput("link_fdx", link_fdx, 1'b0);
`endif

    $display("[TB] RX 1000 mode, preamble + SFD + 60 bytes");
    clearQueues();
    for (int i = 0; i < 7; i++) applyStimulus(2'b11, 8'h55);
    applyStimulus(2'b11, SFD_BYTE);
    for (int i = 1; i <= 60; i++) applyStimulus(2'b11, 8'(i));
    checkOutput("g_eof_early", s_eof, 1'b0);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("g_strip_eof", s_eof, 1'b1);
    checkOutput("g_strip_eof_err", s_eof_err, 1'b0);
    checkOutput("g_eof", rx_bus.eof, 1'b1);
    checkOutput("g_eof_err", rx_bus.eof_err, 1'b0);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("g_eof_pulse", s_eof, 1'b0);
    checkOutput("g_strip_count", s_q_data.size(), 60);
    for (int i = 0; i < 60; i++)
      if (i < s_q_data.size()) checkOutput("g_strip_byte", s_q_data[i], 8'(i + 1));
    if (s_q_sof.size() > 1) begin
      checkOutput("g_strip_sof_first", s_q_sof[0], 1'b1);
      checkOutput("g_strip_sof_second", s_q_sof[1], 1'b0);
    end
    checkOutput("g_count", q_data.size(), 68);
    if (q_data.size() > 8) begin
      checkOutput("g_sof_on_pre", q_sof[0], 1'b1);
      checkOutput("g_byte7_sfd", q_data[7], 8'hD5);
      checkOutput("g_byte8", q_data[8], 8'h01);
    end

    $display("[TB] RX 10/100 mode, odd trailing nibble");
    clearQueues();
    speed1000 = 1'b0;
    for (int i = 0; i < 14; i++) applyNibble(4'h5, 1'b0);
    applyNibble(4'h5, 1'b0);
    applyNibble(4'hD, 1'b0);
    applyNibble(4'h1, 1'b0);
    applyNibble(4'h0, 1'b0);
    applyNibble(4'h7, 1'b0);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("n_eof", rx_bus.eof, 1'b1);
    checkOutput("n_eof_err_odd", rx_bus.eof_err, 1'b1);
    checkOutput("n_strip_eof", s_eof, 1'b1);
    checkOutput("n_strip_eof_err", s_eof_err, 1'b1);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("n_count", q_data.size(), 9);
    if (q_data.size() >= 9) begin
      checkOutput("n_byte6", q_data[6], 8'h55);
      checkOutput("n_byte7", q_data[7], 8'hD5);
      checkOutput("n_byte8", q_data[8], 8'h01);
    end
    checkOutput("n_strip_count", s_q_data.size(), 1);
    if (s_q_data.size() > 0) begin
      checkOutput("n_strip_byte", s_q_data[0], 8'h01);
      checkOutput("n_strip_sof", s_q_sof[0], 1'b1);
    end

    $display("[TB] RX 10/100 mode, error on one nibble of byte 10");
    clearQueues();
    for (int b = 0; b < 12; b++) begin
      applyNibble(4'(b), 1'b0);
      applyNibble(4'h0, b == 10);
    end
    applyStimulus(2'b00, 8'h0D);
    checkOutput("e_eof", rx_bus.eof, 1'b1);
    checkOutput("e_eof_err", rx_bus.eof_err, 1'b1);
    checkOutput("e_strip_no_sfd_eof", s_eof, 1'b0);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("e_count", q_data.size(), 12);
    checkOutput("e_strip_count", s_q_data.size(), 0);
    for (int i = 0; i < 12; i++)
      if (i < q_data.size()) begin
        checkOutput("e_byte", q_data[i], 8'(i));
        checkOutput("e_err_flag", q_err[i], i == 10);
      end

    $display("[TB] RX reset mid-frame");
    speed1000 = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 8'hAA);
    rst_n = 1'b0;
    #1;
    checkOutput("r_rst_valid", rx_bus.valid, 1'b0);
    clearQueues();
    applyStimulus(2'b11, 8'hAA);
    applyStimulus(2'b11, 8'hAA);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 8'hAA);
    checkOutput("r_tail_ignored", q_data.size(), 0);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("r_no_eof", rx_bus.eof, 1'b0);
    applyStimulus(2'b10, 8'h0D);
    applyStimulus(2'b11, 8'h11);
    applyStimulus(2'b11, 8'h22);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("r_new_eof", rx_bus.eof, 1'b1);
    checkOutput("r_new_eof_err", rx_bus.eof_err, 1'b0);
    applyStimulus(2'b00, 8'h0D);
    checkOutput("r_new_count", q_data.size(), 2);
    if (q_data.size() > 0) begin
      checkOutput("r_new_byte0", q_data[0], 8'h11);
      checkOutput("r_new_sof", q_sof[0], 1'b1);
    end

    $display("[TB] TX 1000 mode, 64 bytes then back-to-back frame");
    clearQueues();
    exp_tx.delete();
    for (int i = 0; i < 64; i++) begin
      exp_tx.push_back(8'(i * 7 + 3));
      sendTx(8'(i * 7 + 3));
    end
    endTx();
    gap_cycles = 0;
    gap_bad    = 0;
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(8'(8'hF0 + i));
      sendTx(8'(8'hF0 + i));
    end
    checkOutput("t_gap_cycles", gap_cycles, 12);
    checkOutput("t_gap_ctl", gap_bad, 0);
    endTx();
    repeat (2) tick();
    checkOutput("t_count", tx_q.size(), 68);
    for (int i = 0; i < 68; i++)
      if (i < tx_q.size()) checkOutput("t_byte", tx_q[i], exp_tx[i]);
    repeat (14) tick();

    $display("[TB] TX 10/100 mode, single byte then reset mid-frame");
    clearQueues();
    speed1000 = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 8'hA5;
    checkOutput("m_ready_idle", tx_ready, 1'b1);
    tick();
    checkOutput("m_ready_phase1", tx_ready, 1'b0);
    checkOutput("m_txctl_lo", ddr_txctl, 2'b11);
    checkOutput("m_txd_lo", ddr_txd, 8'h55);
    tick();
    checkOutput("m_ready_phase0", tx_ready, 1'b1);
    checkOutput("m_txd_hi", ddr_txd, 8'hAA);
    tx_valid = 1'b0;
    tick();
    checkOutput("m_txctl_ifg", ddr_txctl, 2'b00);
    gap_cycles = 0;
    gap_bad    = 0;
    sendTx(8'h3C);
    checkOutput("m_gap_cycles", gap_cycles, 24);
    checkOutput("m_gap_ctl", gap_bad, 0);
    checkOutput("m_txctl_frame2", ddr_txctl, 2'b11);
    checkOutput("m_txd_frame2", ddr_txd, 8'hCC);
    rst_n = 1'b0;
    #1;
    checkOutput("m_rst_txctl", ddr_txctl, 2'b00);
    checkOutput("m_rst_txd", ddr_txd, 8'h00);
    checkOutput("m_rst_ready", tx_ready, 1'b0);
    tx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("m_tx_count", tx_q.size(), 3);
    if (tx_q.size() >= 2) begin
      checkOutput("m_tx_q0", tx_q[0], 8'h55);
      checkOutput("m_tx_q1", tx_q[1], 8'hAA);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgmii_byte_adapter.md
RGMII_BYTE_ADAPTER -- requirements
Module: rgmii_byte_adapter

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12; minimum TX inter-frame gap in byte times (range 1..255).
REQ-002 SHALL have parameter RX_STRIP_PRE, default 0; 1 = drop RX preamble/SFD bytes before the first delivered byte.
REQ-003 SHALL have port i_clk, input, 1 bit; the single clock, RGMII link clock after the regional buffer; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port i_speed1000, input, 1 bit; 1 = 1000M byte mode, 0 = 10/100M nibble mode.
REQ-006 SHALL have port i_ddr_rxd, input, 8 bits; DDR capture, [3:0] rising nibble, [7:4] falling nibble.
REQ-007 SHALL have port i_ddr_rxctl, input, 2 bits; [0] = RX_DV (rising), [1] = RX_DV xor RX_ER (falling).
REQ-008 SHALL have port o_rx_data, output, 8 bits; received byte.
REQ-009 SHALL have ports o_rx_valid, o_rx_sof and o_rx_err, outputs, 1 bit each; byte strobe, first byte of frame, and per-byte error.
REQ-010 SHALL have ports o_rx_eof and o_rx_eof_err, outputs, 1 bit each; end-of-frame pulse and frame-bad flag.
REQ-011 SHALL have ports i_tx_data (input, 8 bits), i_tx_valid (input, 1 bit) and o_tx_ready (output, 1 bit); TX byte stream handshake.
REQ-012 SHALL have ports o_ddr_txd (output, 8 bits, [3:0] rising, [7:4] falling) and o_ddr_txctl (output, 2 bits); to ODDR primitives.
REQ-013 SHALL have ports o_link_up (output, 1 bit), o_link_speed (output, 2 bits) and o_link_fdx (output, 1 bit); in-band status.

Function
REQ-014 SHALL derive rx_dv = i_ddr_rxctl[0] and rx_er = i_ddr_rxctl[0] ^ i_ddr_rxctl[1] every cycle.
REQ-015 SHALL run the RX FSM with states IDLE and RECV: IDLE->RECV on rx_dv=1; RECV->IDLE on rx_dv=0.
REQ-016 SHALL latch i_speed1000 on each IDLE->RECV and IDLE->SEND transition; changes mid-frame are ignored until the next frame.
REQ-017 In 1000 mode, SHALL output o_rx_data = i_ddr_rxd with o_rx_valid=1 one cycle after each rx_dv=1 cycle.
REQ-018 In 10/100 mode, SHALL assemble each byte from two consecutive rx_dv cycles, low nibble first, as {second[3:0], first[3:0]}; the phase resets to 0 at frame start.
REQ-019 In 10/100 mode, SHALL assert o_rx_valid one cycle after the second nibble; never on phase 0.
REQ-020 SHALL set o_rx_err with o_rx_valid when rx_er=1 on any contributing cycle; rx_er with rx_dv=0 is not an error.
REQ-021 SHALL assert o_rx_sof with the first delivered byte; with RX_STRIP_PRE=1, bytes up to and including the first 0xD5 are suppressed, and no 0xD5 before rx_dv falls means no bytes and no sof.
REQ-022 SHALL pulse o_rx_eof for 1 cycle, the cycle after rx_dv falls, when at least one byte was delivered; o_rx_eof_err=1 if any o_rx_err, an odd nibble count (dangling nibble dropped), or a missing SFD with strip enabled.
REQ-023 SHALL run the TX FSM with states IDLE, SEND and IFG; o_tx_ready=1 in IDLE and in SEND on accept slots; 0 in IFG.
REQ-024 In 1000 mode, every cycle is an accept slot; an accepted byte SHALL appear next cycle as o_ddr_txd = {data[7:4], data[3:0]} with o_ddr_txctl = 2'b11.
REQ-025 In 10/100 mode, accept slots SHALL be phase-0 cycles only; the byte is output as low nibble on both edges, then high nibble on both edges, over 2 cycles with o_ddr_txctl = 2'b11.
REQ-026 SHALL treat i_tx_valid=0 at an accept slot in SEND as end of frame; the FSM goes SEND->IFG with o_ddr_txctl = 2'b00 and o_ddr_txd = 0.
REQ-027 SHALL hold IFG for IFG_BYTES cycles (1000) or 2*IFG_BYTES cycles (10/100) using a counter, then go to IDLE.
REQ-028 SHALL support a back-to-back new frame offered during IFG, stalled by o_tx_ready=0 until IDLE.

Reset
REQ-029 While i_rst_n=0, SHALL immediately drive both FSMs to IDLE, counters, phases and all outputs to 0 except o_tx_ready=0.
REQ-030 Reset mid-frame SHALL emit no o_rx_eof; after release, RX waits for rx_dv=0 before it can re-enter RECV.

Configuration
REQ-031 With RGMII_INBAND_STATUS_EN defined, SHALL latch o_link_up = rxd[0], o_link_speed = rxd[2:1] and o_link_fdx = rxd[3] (rising nibble) each cycle with rx_dv=0 and rx_er=0.
REQ-032 Without RGMII_INBAND_STATUS_EN, SHALL keep those ports present and tie them to 0.

Structure
REQ-033 SHALL place the RX/TX state enums, the speed encoding (00=10M, 01=100M, 10=1000M) and the IFG_BYTES default in package rgmii_pkg.
REQ-034 SHALL implement the RX path in sub-module rgmii_rx_assembler; TX stays in the top.

Verification
REQ-035 1000 mode, RX 7x0x55, 0xD5, 0x01..0x3C (60 B), RX_STRIP_PRE=1 -> 60 valid bytes, sof on 0x01, eof 1 cycle after dv falls, eof_err=0.
REQ-036 10/100 mode, rising nibbles 5,5,...,5,D,1,0 -> bytes ...0x55, 0xD5, 0x01; an odd trailing nibble -> eof_err=1.
REQ-037 RX with rx_er on 1 nibble of byte 10 -> o_rx_err only on byte 10; eof_err=1.
REQ-038 TX 1000 mode, 64-byte frame then immediate second frame, IFG_BYTES=12 -> ready low exactly 12 cycles, txctl 00 in the gap.
REQ-039 TX 10/100 mode, byte 0xA5 -> txd 0x55 then 0xAA, ready high every other cycle; i_rst_n pulse mid-frame -> txctl 00 immediately.
REQ-040 With RGMII_INBAND_STATUS_EN, idle rxd = 0xD (rising nibble) -> link_up=1, speed=10, fdx=1; without the macro -> all 0.
